board_grid: RTL and testbench

- Parametrised playfield store for the tetris core, successor of the fixed 10x20 board.
- Holds per-cell colour codes and applies piece erase/write on updates.
- Reports collision legality for NUM_CAND candidate placements.
- On lock, detects every full row at once, flashes them for CLEAR_FRAMES frames, then compacts non-contiguous cleared rows in one pass; also provides a registered read port for the renderer.

---
 rtl/board_grid_pkg.sv | 40 ++++
 rtl/board_collision.sv | 44 ++++
 rtl/board_grid.sv | 221 ++++++++++++++++++++++
 tb/tb_board_grid.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_grid_pkg.sv
// Shared types and defaults for the playfield store.
// Colour codes, board states and coordinate unpacking.
package board_grid_pkg;

  localparam int DEF_X_SIZE       = 10;
  localparam int DEF_Y_SIZE       = 20;
  localparam int DEF_COORD_W      = 5;
  localparam int DEF_CELL_W       = 3;
  localparam int DEF_NUM_CAND     = 5;
  localparam int DEF_CLEAR_FRAMES = 3;

  typedef enum logic [DEF_CELL_W-1:0] {
    EMPTY  = 3'd0,
    CYAN   = 3'd1,
    BLUE   = 3'd2,
    ORANGE = 3'd3,
    YELLOW = 3'd4,
    GREEN  = 3'd5,
    PURPLE = 3'd6,
    RED    = 3'd7
  } block_color_e;

  typedef enum logic [1:0] {
    PLAY    = 2'd0,
    FLASH   = 2'd1,
    COMPACT = 2'd2
  } board_state_e;

  // Field k of a vector of w-bit coordinates, as an int.
  function automatic int coord_at(
    input logic [127:0] v,
    input int           k,
    input int           w
  );
    logic [127:0] m;
    m = (128'd1 << w) - 128'd1;
    return int'((v >> (k * w)) & m);
  endfunction

endpackage

// File: rtl/board_collision.sv
// Legality check for one candidate piece placement.
// In range, and each cell free or owned by the current piece.
module board_collision
  import board_grid_pkg::*;
#(
  parameter int X_SIZE  = DEF_X_SIZE,
  parameter int Y_SIZE  = DEF_Y_SIZE,
  parameter int COORD_W = DEF_COORD_W
)(
  input  logic [4*COORD_W-1:0]     x,
  input  logic [4*COORD_W-1:0]     y,
  input  logic [4*COORD_W-1:0]     piece_x,
  input  logic [4*COORD_W-1:0]     piece_y,
  input  logic [X_SIZE*Y_SIZE-1:0] occ,
  output logic                     ok
);

  int cx;
  int cy;
  logic own;

  // Walk the four cells; any out-of-range or foreign hit fails.
  always_comb begin
    ok  = 1'b1;
    cx  = 0;
    cy  = 0;
    own = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cx = coord_at(128'(x), k, COORD_W);
      cy = coord_at(128'(y), k, COORD_W);
      if (cx >= X_SIZE || cy >= Y_SIZE) begin
        ok = 1'b0;
      end else if (occ[cy*X_SIZE+cx]) begin
        own = 1'b0;
        for (int j = 0; j < 4; j++)
          if (coord_at(128'(piece_x), j, COORD_W) == cx &&
              coord_at(128'(piece_y), j, COORD_W) == cy)
            own = 1'b1;
        if (!own) ok = 1'b0;
      end
    end
  end

endmodule

// File: rtl/board_grid.sv
// Playfield store: piece writes, collision, line clear.
// Full rows flash, then compact bottom-up in one pass.
module board_grid
  import board_grid_pkg::*;
#(
  parameter int X_SIZE       = DEF_X_SIZE,
  parameter int Y_SIZE       = DEF_Y_SIZE,
  parameter int COORD_W      = DEF_COORD_W,
  parameter int CELL_W       = DEF_CELL_W,
  parameter int NUM_CAND     = DEF_NUM_CAND,
  parameter int CLEAR_FRAMES = DEF_CLEAR_FRAMES
)(
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         frame_tick,
  input  logic [COORD_W-1:0]           rd_x,
  input  logic [COORD_W-1:0]           rd_y,
  output logic [CELL_W-1:0]            rd_cell,
  input  logic [4*COORD_W-1:0]         piece_x,
  input  logic [4*COORD_W-1:0]         piece_y,
  input  logic [4*COORD_W-1:0]         prev_x,
  input  logic [4*COORD_W-1:0]         prev_y,
  input  logic [CELL_W-1:0]            piece_color,
  input  logic                         piece_update,
  input  logic                         piece_new,
  input  logic                         piece_lock,
  input  logic [NUM_CAND*4*COORD_W-1:0] cand_x,
  input  logic [NUM_CAND*4*COORD_W-1:0] cand_y,
  output logic [NUM_CAND-1:0]          cand_ok,
  output logic                         busy,
  output logic [Y_SIZE-1:0]            flash_rows,
  output logic [2:0]                   lines_cleared,
  output logic                         clear_done,
  output logic                         top_out
);

  localparam int FW = $clog2(CLEAR_FRAMES + 1);
  localparam logic [FW-1:0] LAST = FW'(CLEAR_FRAMES - 1);
  localparam logic [COORD_W-1:0] XS = COORD_W'(X_SIZE);
  localparam logic [COORD_W-1:0] YS = COORD_W'(Y_SIZE);

  logic [CELL_W-1:0] cells   [Y_SIZE][X_SIZE];
  logic [CELL_W-1:0] upd     [Y_SIZE][X_SIZE];
  logic [CELL_W-1:0] cmp_row [X_SIZE];

  board_state_e state, state_nx;
  logic [Y_SIZE-1:0]         full_mask;
  logic [Y_SIZE-1:0]         clr_mask;
  logic [X_SIZE*Y_SIZE-1:0]  occ;
  logic [FW-1:0]             frame_cnt;
  logic [COORD_W-1:0]        dst;
  logic signed [COORD_W:0]   src;
  logic                      upd_top;
  logic                      cmp_any;
  int                        sel;
  int                        px;
  int                        py;

  assign busy = (state != PLAY);

  // Board as it would look after this cycle's update (erase then write).
  always_comb begin
    upd = cells;
    px  = 0;
    py  = 0;
    if (state == PLAY && piece_update) begin
      if (!piece_new)
        for (int k = 0; k < 4; k++) begin
          px = coord_at(128'(prev_x), k, COORD_W);
          py = coord_at(128'(prev_y), k, COORD_W);
          if (px < X_SIZE && py < Y_SIZE)
            upd[py][px] = CELL_W'(EMPTY);
        end
      for (int k = 0; k < 4; k++) begin
        px = coord_at(128'(piece_x), k, COORD_W);
        py = coord_at(128'(piece_y), k, COORD_W);
        if (px < X_SIZE && py < Y_SIZE)
          upd[py][px] = piece_color;
      end
    end
  end

  // Full rows and top-row occupancy of the updated board.
  always_comb begin
    upd_top = 1'b0;
    for (int yy = 0; yy < Y_SIZE; yy++) begin
      full_mask[yy] = 1'b1;
      for (int xx = 0; xx < X_SIZE; xx++)
        if (upd[yy][xx] == '0) full_mask[yy] = 1'b0;
    end
    for (int xx = 0; xx < X_SIZE; xx++)
      if (upd[0][xx] != '0) upd_top = 1'b1;
  end

  // Occupancy map of the stored board for the candidate checkers.
  always_comb begin
    for (int yy = 0; yy < Y_SIZE; yy++)
      for (int xx = 0; xx < X_SIZE; xx++)
        occ[yy*X_SIZE+xx] = (cells[yy][xx] != '0);
  end

  // Next surviving source row at or above src, and its contents.
  always_comb begin
    sel     = -1;
    cmp_any = 1'b0;
    for (int xx = 0; xx < X_SIZE; xx++) cmp_row[xx] = '0;
    for (int r = Y_SIZE - 1; r >= 0; r--)
      if (sel < 0 && r <= int'(src) && !clr_mask[r]) sel = r;
    if (sel >= 0) cmp_row = cells[sel];
    for (int xx = 0; xx < X_SIZE; xx++)
      if (cmp_row[xx] != '0) cmp_any = 1'b1;
  end

  genvar n;
  generate
    for (n = 0; n < NUM_CAND; n++) begin : g_cand
      board_collision #(
        .X_SIZE (X_SIZE),
        .Y_SIZE (Y_SIZE),
        .COORD_W(COORD_W)
      ) u_chk (
        .x      (cand_x[n*4*COORD_W +: 4*COORD_W]),
        .y      (cand_y[n*4*COORD_W +: 4*COORD_W]),
        .piece_x(piece_x),
        .piece_y(piece_y),
        .occ    (occ),
        .ok     (cand_ok[n])
      );
    end
  endgenerate

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= PLAY;
    else       state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      PLAY:    if (piece_lock && full_mask != '0) state_nx = FLASH;
      FLASH:   if (frame_tick && frame_cnt == LAST) state_nx = COMPACT;
      COMPACT: if (dst == '0) state_nx = PLAY;
      default: state_nx = PLAY;
    endcase
  end

  // Registered renderer read; out-of-range reads return EMPTY.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      rd_cell <= '0;
    else if (rd_x < XS && rd_y < YS)
      rd_cell <= cells[rd_y][rd_x];
    else
      rd_cell <= '0;
  end

  // Board contents, clear bookkeeping and status flags.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int yy = 0; yy < Y_SIZE; yy++)
        for (int xx = 0; xx < X_SIZE; xx++)
          cells[yy][xx] <= '0;
      flash_rows    <= '0;
      clr_mask      <= '0;
      lines_cleared <= '0;
      clear_done    <= 1'b0;
      top_out       <= 1'b0;
      frame_cnt     <= '0;
      dst           <= '0;
      src           <= '0;
    end else begin
      clear_done <= 1'b0;
      unique case (state)
        PLAY: begin
          cells <= upd;
          if (piece_lock) begin
            clr_mask      <= full_mask;
            lines_cleared <= 3'($countones(full_mask));
            frame_cnt     <= '0;
            if (full_mask != '0) begin
              flash_rows <= full_mask;
            end else begin
              clear_done <= 1'b1;
              if (upd_top) top_out <= 1'b1;
            end
          end
        end
        FLASH: begin
          if (frame_tick) begin
            if (frame_cnt == LAST) begin
              for (int yy = 0; yy < Y_SIZE; yy++)
                if (clr_mask[yy])
                  for (int xx = 0; xx < X_SIZE; xx++)
                    cells[yy][xx] <= '0;
              flash_rows <= '0;
              frame_cnt  <= '0;
              dst        <= YS - 1'b1;
              src        <= (COORD_W+1)'(Y_SIZE - 1);
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        COMPACT: begin
          cells[dst] <= cmp_row;
          dst        <= dst - 1'b1;
          if (sel < 0) src <= '1;
          else         src <= (COORD_W+1)'(sel - 1);
          if (dst == '0) begin
            clear_done <= 1'b1;
            if (cmp_any) top_out <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_board_grid.sv
// Directed bench for board_grid.
// Each task drives one scenario and checks inline.
module tb_board_grid;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          frame_tick = 1'b0;
  logic [4:0]    rd_x = '0;
  logic [4:0]    rd_y = '0;
  logic [2:0]    rd_cell;
  logic [19:0]   piece_x = '0;
  logic [19:0]   piece_y = '0;
  logic [19:0]   prev_x = '0;
  logic [19:0]   prev_y = '0;
  logic [2:0]    piece_color = '0;
  logic          piece_update = 1'b0;
  logic          piece_new = 1'b0;
  logic          piece_lock = 1'b0;
  logic [99:0]   cand_x = '0;
  logic [99:0]   cand_y = '0;
  logic [4:0]    cand_ok;
  logic          busy;
  logic [19:0]   flash_rows;
  logic [2:0]    lines_cleared;
  logic          clear_done;
  logic          top_out;

  int errs = 0;
  int checks = 0;

  board_grid dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_tick   (frame_tick),
    .rd_x         (rd_x),
    .rd_y         (rd_y),
    .rd_cell      (rd_cell),
    .piece_x      (piece_x),
    .piece_y      (piece_y),
    .prev_x       (prev_x),
    .prev_y       (prev_y),
    .piece_color  (piece_color),
    .piece_update (piece_update),
    .piece_new    (piece_new),
    .piece_lock   (piece_lock),
    .cand_x       (cand_x),
    .cand_y       (cand_y),
    .cand_ok      (cand_ok),
    .busy         (busy),
    .flash_rows   (flash_rows),
    .lines_cleared(lines_cleared),
    .clear_done   (clear_done),
    .top_out      (top_out)
  );

  always #5 Clk = ~Clk;

  function automatic logic [19:0] p4(input int a, b, c, d);
    return {5'(d), 5'(c), 5'(b), 5'(a)};
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic place(input logic [19:0] xs, ys,
                       input int col, input bit nw,
                       input bit lk);
    piece_x      = xs;
    piece_y      = ys;
    piece_color  = 3'(col);
    piece_update = 1'b1;
    piece_new    = nw;
    piece_lock   = lk;
    tick();
    piece_update = 1'b0;
    piece_new    = 1'b0;
    piece_lock   = 1'b0;
  endtask

  task automatic rd(input int x, y, output logic [2:0] v);
    rd_x = 5'(x);
    rd_y = 5'(y);
    tick();
    v = rd_cell;
  endtask

  task automatic pulse_frame();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [2:0] v;
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    tick();
    rd(3, 7, v);
    checks++;
    if (v !== 3'd0) begin
      errs++;
      $display("FAIL reset_rd got=%0d want=0", v);
    end
    checks++;
    if (busy !== 1'b0 || top_out !== 1'b0) begin
      errs++;
      $display("FAIL reset_flags busy=%b top=%b want=0,0",
               busy, top_out);
    end
    checks++;
    if (flash_rows !== 20'h0 || lines_cleared !== 3'd0 ||
        clear_done !== 1'b0) begin
      errs++;
      $display("FAIL reset_status fr=%h lc=%0d cd=%b want=0",
               flash_rows, lines_cleared, clear_done);
    end
  endtask

  task automatic test_place();
    logic [2:0] v;
    place(p4(0, 1, 2, 3), p4(19, 19, 19, 19), 1, 1, 0);
    for (int i = 0; i < 4; i++) begin
      rd(i, 19, v);
      checks++;
      if (v !== 3'd1) begin
        errs++;
        $display("FAIL place_cell%0d got=%0d want=1", i, v);
      end
    end
    cand_x = {p4(0, 1, 2, 3), p4(0, 1, 2, 3),
              p4(5, 5, 5, 5), p4(1, 2, 3, 4),
              p4(-1, 0, 1, 2)};
    cand_y = {p4(20, 20, 20, 20), p4(16, 17, 18, 19),
              p4(0, 1, 2, 3), p4(19, 19, 19, 19),
              p4(19, 19, 19, 19)};
    #1;
    checks++;
    if (cand_ok !== 5'b01110) begin
      errs++;
      $display("FAIL cand_ok got=%b want=01110", cand_ok);
    end
    rd(15, 0, v);
    checks++;
    if (v !== 3'd0) begin
      errs++;
      $display("FAIL rd_oob got=%0d want=0", v);
    end
  endtask

  task automatic test_move();
    logic [2:0] v0, v4, v2;
    prev_x = p4(0, 1, 2, 3);
    prev_y = p4(19, 19, 19, 19);
    place(p4(1, 2, 3, 4), p4(19, 19, 19, 19), 1, 0, 0);
    rd(0, 19, v0);
    rd(4, 19, v4);
    rd(2, 19, v2);
    checks++;
    if (v0 !== 3'd0 || v4 !== 3'd1 || v2 !== 3'd1) begin
      errs++;
      $display("FAIL move got=%0d,%0d,%0d want=0,1,1",
               v0, v4, v2);
    end
  endtask

  task automatic test_clear();
    logic [2:0] v;
    int n;
    place(p4(0, 1, 2, 3), p4(19, 19, 19, 19), 2, 1, 0);
    place(p4(4, 5, 6, 7), p4(19, 19, 19, 19), 2, 1, 0);
    place(p4(8, 8, 8, 8), p4(19, 19, 19, 19), 2, 1, 0);
    place(p4(0, 1, 2, 3), p4(17, 17, 17, 17), 5, 1, 0);
    place(p4(4, 5, 6, 7), p4(17, 17, 17, 17), 5, 1, 0);
    place(p4(8, 8, 8, 8), p4(17, 17, 17, 17), 5, 1, 0);
    place(p4(0, 0, 0, 0), p4(18, 18, 18, 18), 3, 1, 0);
    place(p4(5, 5, 5, 5), p4(18, 18, 18, 18), 4, 1, 0);
    place(p4(2, 2, 2, 2), p4(16, 16, 16, 16), 6, 1, 0);
    place(p4(9, 9, 9, 9), p4(16, 17, 18, 19), 7, 1, 1);
    checks++;
    if (busy !== 1'b1 || flash_rows !== 20'hA0000 ||
        lines_cleared !== 3'd2) begin
      errs++;
      $display("FAIL lock2 busy=%b fr=%h lc=%0d want=1,a0000,2",
               busy, flash_rows, lines_cleared);
    end
    place(p4(0, 0, 0, 0), p4(0, 0, 0, 0), 1, 1, 1);
    pulse_frame();
    pulse_frame();
    checks++;
    if (busy !== 1'b1 || flash_rows !== 20'hA0000) begin
      errs++;
      $display("FAIL flash_hold busy=%b fr=%h want=1,a0000",
               busy, flash_rows);
    end
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    checks++;
    if (flash_rows !== 20'h0 || busy !== 1'b1) begin
      errs++;
      $display("FAIL flash_end fr=%h busy=%b want=0,1",
               flash_rows, busy);
    end
    n = 0;
    while (clear_done !== 1'b1 && n < 40) begin
      frame_tick = (n == 3);
      tick();
      frame_tick = 1'b0;
      n++;
    end
    checks++;
    if (n != 20) begin
      errs++;
      $display("FAIL compact_len got=%0d want=20", n);
    end
    checks++;
    if (busy !== 1'b0 || lines_cleared !== 3'd2) begin
      errs++;
      $display("FAIL post_clear busy=%b lc=%0d want=0,2",
               busy, lines_cleared);
    end
    rd(0, 19, v);
    checks++;
    if (clear_done !== 1'b0) begin
      errs++;
      $display("FAIL done_pulse got=%b want=0", clear_done);
    end
    checks++;
    if (v !== 3'd3) begin
      errs++;
      $display("FAIL row19_x0 got=%0d want=3", v);
    end
    rd(5, 19, v);
    checks++;
    if (v !== 3'd4) begin
      errs++;
      $display("FAIL row19_x5 got=%0d want=4", v);
    end
    rd(9, 19, v);
    checks++;
    if (v !== 3'd7) begin
      errs++;
      $display("FAIL row19_x9 got=%0d want=7", v);
    end
    rd(1, 19, v);
    checks++;
    if (v !== 3'd0) begin
      errs++;
      $display("FAIL row19_x1 got=%0d want=0", v);
    end
    rd(2, 18, v);
    checks++;
    if (v !== 3'd6) begin
      errs++;
      $display("FAIL row18_x2 got=%0d want=6", v);
    end
    rd(0, 17, v);
    checks++;
    if (v !== 3'd0) begin
      errs++;
      $display("FAIL row17_x0 got=%0d want=0", v);
    end
    rd(0, 0, v);
    checks++;
    if (v !== 3'd0 || top_out !== 1'b0) begin
      errs++;
      $display("FAIL busy_ignored cell=%0d top=%b want=0,0",
               v, top_out);
    end
  endtask

  task automatic test_no_clear();
    piece_lock = 1'b1;
    tick();
    piece_lock = 1'b0;
    checks++;
    if (clear_done !== 1'b1 || lines_cleared !== 3'd0 ||
        busy !== 1'b0) begin
      errs++;
      $display("FAIL lock0 cd=%b lc=%0d busy=%b want=1,0,0",
               clear_done, lines_cleared, busy);
    end
    tick();
    checks++;
    if (clear_done !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL lock0_after cd=%b busy=%b want=0,0",
               clear_done, busy);
    end
  endtask

  task automatic test_top_out();
    logic [2:0] v;
    place(p4(5, 5, 5, 5), p4(0, 1, 2, 3), 3, 1, 1);
    checks++;
    if (top_out !== 1'b1 || clear_done !== 1'b1) begin
      errs++;
      $display("FAIL top_set top=%b cd=%b want=1,1",
               top_out, clear_done);
    end
    rd(5, 0, v);
    checks++;
    if (v !== 3'd3) begin
      errs++;
      $display("FAIL top_cell got=%0d want=3", v);
    end
    piece_lock = 1'b1;
    tick();
    piece_lock = 1'b0;
    tick();
    checks++;
    if (top_out !== 1'b1) begin
      errs++;
      $display("FAIL top_sticky got=%b want=1", top_out);
    end
  endtask

  task automatic test_reset_compact();
    logic [2:0] v;
    place(p4(0, 1, 2, 3), p4(19, 19, 19, 19), 1, 1, 0);
    place(p4(4, 5, 6, 7), p4(19, 19, 19, 19), 1, 1, 0);
    place(p4(8, 8, 8, 8), p4(19, 19, 19, 19), 1, 1, 1);
    checks++;
    if (busy !== 1'b1 || flash_rows !== 20'h80000 ||
        lines_cleared !== 3'd1) begin
      errs++;
      $display("FAIL lock1 busy=%b fr=%h lc=%0d want=1,80000,1",
               busy, flash_rows, lines_cleared);
    end
    pulse_frame();
    pulse_frame();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    #2;
    Reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || top_out !== 1'b0 ||
        rd_cell !== 3'd0 || flash_rows !== 20'h0) begin
      errs++;
      $display("FAIL mid_reset busy=%b top=%b rd=%0d fr=%h",
               busy, top_out, rd_cell, flash_rows);
    end
    tick();
    Reset = 1'b0;
    rd(5, 1, v);
    checks++;
    if (v !== 3'd0) begin
      errs++;
      $display("FAIL mid_reset_c51 got=%0d want=0", v);
    end
    rd(2, 18, v);
    checks++;
    if (v !== 3'd0) begin
      errs++;
      $display("FAIL mid_reset_c218 got=%0d want=0", v);
    end
    rd(9, 19, v);
    checks++;
    if (v !== 3'd0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL mid_reset_c919 got=%0d busy=%b want=0,0",
               v, busy);
    end
  endtask

  initial begin
    test_reset();
    test_place();
    test_move();
    test_clear();
    test_no_clear();
    test_top_out();
    test_reset_compact();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
